// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop driver: FSM states, excitation
// encoding and the excitation helper used to pick s/r from target/current.
package sr_pkg;

    // Driver sequencing: wait for work, pulse s/r, sample feedback.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Excitation word packed as {s, r}.
    typedef logic [1:0] exc_t;

    localparam exc_t HOLD = 2'b00;
    localparam exc_t SET  = 2'b10;
    localparam exc_t RST  = 2'b01;

    // Pick the excitation that moves the flip-flop from cur to tgt.
    // Only HOLD, SET or RST can come out, so s and r are never both high.
    function automatic exc_t excite(input logic tgt, input logic cur);
        exc_t result;
        if (tgt == cur) begin
            result = HOLD;
        end else if (tgt) begin
            result = SET;
        end else begin
            result = RST;
        end
        return result;
    endfunction

endpackage

// File: rtl/sr_fifo.sv
// Small first-word-fall-through FIFO holding target bits for the driver.
// Occupancy is kept in a register so full/empty are glitch-free flop outputs.
module sr_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        push_data,
    input  logic        pop,
    output logic        pop_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    // Requests are qualified here so a misbehaving caller can never
    // overrun or underrun the storage.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full     = (count_reg == (AW + 1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    // Occupancy update: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage write; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/sr_driver.sv
// Drives an external SR flip-flop toward a stream of queued target bits.
// Each bit takes two cycles: DRIVE presents a one-cycle s/r pulse, CHECK
// samples the fed-back Q, flags a mismatch and resynchronises to what was
// actually observed so later excitations stay correct.
module sr_driver
    import sr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);

    state_t           state_reg;
    state_t           state_next;
    exc_t             exc_reg;
    exc_t             exc_next;
    logic             ready_en_reg;
    logic             cur_reg;
    logic             tgt_q_reg;
    logic             mismatch_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic             check_miss;

    sr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (tgt_bit),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready is held low during reset and for the release cycle, then
    // follows the registered occupancy.
    assign tgt_ready = ready_en_reg && !fifo_full;
    assign fifo_push = tgt_valid && tgt_ready;

    // A CHECK cycle whose feedback disagrees with the bit just driven.
    assign check_miss = (state_reg == CHECK) && (q_fb != tgt_q_reg);

    assign s        = exc_reg[1];
    assign r        = exc_reg[0];
    assign mismatch = mismatch_reg;
    assign err_cnt  = err_cnt_reg;
    assign busy     = (state_reg != IDLE) || (fifo_count != '0);

    // Next state, head pop and excitation for the upcoming DRIVE cycle.
    // Leaving CHECK uses q_fb directly because cur_reg only catches up
    // with the observed state at this same edge.
    always_comb begin
        state_next = state_reg;
        exc_next   = HOLD;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = DRIVE;
                    exc_next   = excite(fifo_head, cur_reg);
                end
            end
            DRIVE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = DRIVE;
                    exc_next   = excite(fifo_head, q_fb);
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Registered excitation: non-HOLD only during the DRIVE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_reg <= HOLD;
        end else begin
            exc_reg <= exc_next;
        end
    end

    // Ready enable: first edge after reset release opens the input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // Latch the popped target; track the flip-flop state as observed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q_reg <= 1'b0;
            cur_reg   <= 1'b0;
        end else begin
            if (fifo_pop) begin
                tgt_q_reg <= fifo_head;
            end
            if (state_reg == CHECK) begin
                cur_reg <= q_fb;
            end
        end
    end

    // Mismatch pulse and saturating error counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            mismatch_reg <= check_miss;
            if (check_miss && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sr_driver.sv
// Bench for sr_driver: a behavioural SR flip-flop closes the feedback loop,
// a scoreboard queues expected pulses and mismatch reports at push time,
// and a monitor pops and compares them as the design produces them.
module tb_sr_driver;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tgt_valid = 1'b0;
    logic       tgt_bit = 1'b0;
    logic       q_force = 1'b0;
    logic       srff_q;
    logic       q_fb;
    logic       push_obs;
    logic       tgt_ready, s, r, busy, mismatch;
    logic [7:0] err_cnt;
    logic       tgt_ready2, s2, r2, busy2, mismatch2;
    logic [1:0] err_cnt2;

    typedef struct packed {
        logic [7:0] e8;
        logic [1:0] e2;
    } mis_t;

    logic [1:0] exc_q[$];
    mis_t       mis_q[$];
    logic       model_cur;
    logic [7:0] model_err8;
    logic [1:0] model_err2;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_pulses = 0;
    bit         done = 1'b0;

    always #5 clk = ~clk;

    assign q_fb     = q_force ? 1'b0 : srff_q;
    assign push_obs = q_force ? 1'b0 : tgt_bit;

    // Behavioural SR flip-flop with active-low reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) srff_q <= 1'b0;
        else if (s && !r) srff_q <= 1'b1;
        else if (r && !s) srff_q <= 1'b0;
    end

    sr_driver #(.DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .s(s), .r(r), .q_fb(q_fb), .busy(busy),
        .mismatch(mismatch), .err_cnt(err_cnt)
    );

    sr_driver #(.DEPTH(DEPTH), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready2), .s(s2), .r(r2), .q_fb(q_fb), .busy(busy2),
        .mismatch(mismatch2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    // Scoreboard: predict pulse and mismatch for every accepted bit.
    task automatic sb_loop();
        while (!done) begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                exc_q.delete();
                mis_q.delete();
                model_cur  = 1'b0;
                model_err8 = 8'd0;
                model_err2 = 2'd0;
            end else if (tgt_valid && tgt_ready) begin
                if (tgt_bit != model_cur) exc_q.push_back(tgt_bit ? 2'b10 : 2'b01);
                if (push_obs != tgt_bit) begin
                    if (model_err8 != 8'hFF) model_err8 = model_err8 + 8'd1;
                    if (model_err2 != 2'b11) model_err2 = model_err2 + 2'd1;
                    mis_q.push_back({model_err8, model_err2});
                end
                model_cur = push_obs;
            end
        end
    endtask

    // Monitor: compare each observed pulse / mismatch against the queues.
    task automatic monitor_loop();
        logic [1:0] e;
        mis_t m;
        while (!done) begin
            @(negedge clk);
            chk("sr_exclusive", 32'(s & r), 0);
            chk("sr2_exclusive", 32'(s2 & r2), 0);
            if (s || r) begin
                n_pulses++;
                if (exc_q.size() == 0) chk("unexpected_pulse", {30'd0, s, r}, 0);
                else begin
                    e = exc_q.pop_front();
                    chk("pulse_sr", {30'd0, s, r}, {30'd0, e});
                end
            end
            if (mismatch) begin
                if (mis_q.size() == 0) chk("unexpected_mismatch", 32'(mismatch), 0);
                else begin
                    m = mis_q.pop_front();
                    chk("err_cnt", 32'(err_cnt), 32'(m.e8));
                    chk("err_cnt_w2", 32'(err_cnt2), 32'(m.e2));
                    chk("mismatch_w2", 32'(mismatch2), 1);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 0);
        @(negedge clk);
    endtask

    task automatic drained();
        chk("pulses_left", exc_q.size(), 0);
        chk("mismatches_left", mis_q.size(), 0);
    endtask

    // Hold valid until n bits are accepted; report accepted count at first stall.
    task automatic push_seq(input logic [15:0] bits, input int n, output int first_drop);
        int idx = 0;
        int guard = 0;
        first_drop = -1;
        while (idx < n && guard < 200) begin
            @(negedge clk);
            tgt_valid = 1'b1;
            tgt_bit   = bits[idx];
            if (tgt_ready) idx++;
            else if (first_drop < 0) first_drop = idx;
            guard++;
        end
        chk("push_seq_done", idx, n);
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    // Single push from idle with cycle-exact latency checks.
    task automatic push_timed(input logic b, input logic [1:0] exp_sr, input logic exp_mis);
        wait_idle();
        tgt_valid = 1'b1;
        tgt_bit   = b;
        chk("ready_before_push", 32'(tgt_ready), 1);
        @(negedge clk);              // edge N passed
        tgt_valid = 1'b0;
        @(negedge clk);              // after N+1
        chk("sr_at_n1", {30'd0, s, r}, {30'd0, exp_sr});
        @(negedge clk);              // after N+2
        chk("sr_at_n2", {30'd0, s, r}, 0);
        chk("mismatch_at_n2", 32'(mismatch), 0);
        @(negedge clk);              // after N+3
        chk("mismatch_at_n3", 32'(mismatch), 32'(exp_mis));
        @(negedge clk);
        chk("mismatch_at_n4", 32'(mismatch), 0);
    endtask

    task automatic main_seq();
        int drop;
        int p0;
        int k;
        logic last_tgt;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s", 32'(s), 0);
        chk("rst_r", 32'(r), 0);
        chk("rst_ready", 32'(tgt_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_ready_w2", 32'(tgt_ready2), 0);
        chk("rst_busy_w2", 32'(busy2), 0);
        reset = 1'b1;
        chk("ready_at_release", 32'(tgt_ready), 0);
        @(negedge clk);
        chk("ready_after_release", 32'(tgt_ready), 1);

        // 1,0,0,1 -> SET, RST, HOLD, SET
        p0 = n_pulses;
        push_seq(16'b1001, 4, drop);
        wait_idle();
        chk("seq1_pulses", n_pulses - p0, 3);
        chk("seq1_q", 32'(q_fb), 1);
        chk("seq1_err", 32'(err_cnt), 0);
        drained();

        // Back-to-back stream of 8 alternating bits fills the FIFO
        p0 = n_pulses;
        push_seq(16'hAA, 8, drop);
        chk("first_ready_drop", drop, 7);
        wait_idle();
        chk("stream_pulses", n_pulses - p0, 8);
        chk("stream_q", 32'(q_fb), 1);
        drained();

        // Forced feedback mismatch and resync
        push_timed(1'b0, 2'b01, 1'b0);
        q_force = 1'b1;
        push_timed(1'b1, 2'b10, 1'b1);
        chk("forced_err", 32'(err_cnt), 1);
        q_force = 1'b0;
        push_timed(1'b1, 2'b10, 1'b0);
        chk("resync_err", 32'(err_cnt), 1);
        drained();

        // Five forced mismatches: narrow counter saturates
        q_force = 1'b1;
        push_seq(16'h1F, 5, drop);
        wait_idle();
        q_force = 1'b0;
        chk("sat_err8", 32'(err_cnt), 6);
        chk("sat_err2", 32'(err_cnt2), 3);
        push_timed(1'b1, 2'b10, 1'b0);
        chk("sat_err2_hold", 32'(err_cnt2), 3);
        drained();

        // Reset in the middle of a DRIVE cycle
        push_seq(16'h0002, 3, drop);
        k = 0;
        while (!(s || r) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("drive_seen", 32'(s | r), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_s", 32'(s), 0);
        chk("abort_r", 32'(r), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(tgt_ready), 0);
        chk("abort_err", 32'(err_cnt), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("rerelease_ready", 32'(tgt_ready), 0);
        @(negedge clk);
        chk("rerelease_ready_up", 32'(tgt_ready), 1);
        chk("rerelease_empty", 32'(busy), 0);
        push_timed(1'b1, 2'b10, 1'b0);

        // Random traffic
        last_tgt = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_bit   = 1'($urandom_range(0, 1));
            if (tgt_valid && tgt_ready) last_tgt = tgt_bit;
        end
        @(negedge clk);
        tgt_valid = 1'b0;
        wait_idle();
        chk("rand_final_q", 32'(q_fb), 32'(last_tgt));
        chk("rand_err", 32'(err_cnt), 0);
        drained();
    endtask

    initial begin
        fork
            sb_loop();
            monitor_loop();
            begin
                main_seq();
                done = 1'b1;
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sr_driver.md
SR_DRIVER -- requirements
Module: sr_driver

Interface
REQ-001 Parameter DEPTH, default 4: target-bit FIFO depth; power of two, 2..16.
REQ-002 Parameter ERR_W, default 8: width of the mismatch error counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 tgt_valid  input  1  upstream has a target Q bit.
REQ-006 tgt_bit  input  1  desired next state of the external SR flip-flop.
REQ-007 tgt_ready  output  1  FIFO can accept; transfer occurs when tgt_valid and tgt_ready are both 1 at posedge.
REQ-008 s  output  1  set excitation to the external SR flip-flop.
REQ-009 r  output  1  reset excitation to the external SR flip-flop.
REQ-010 q_fb  input  1  Q fed back from the external SR flip-flop.
REQ-011 busy  output  1  1 while FSM is not IDLE or FIFO is non-empty.
REQ-012 mismatch  output  1  one-cycle pulse: sampled q_fb differed from the target.
REQ-013 err_cnt  output  ERR_W  saturating count of mismatches.

Function
REQ-014 FIFO: push on tgt_valid&&tgt_ready; tgt_ready = !full from registered occupancy; pointers wrap modulo DEPTH.
REQ-015 When full, tgt_ready = 0; a pop at that edge raises tgt_ready on the following cycle; no push is ever lost or duplicated.
REQ-016 FSM states: IDLE, DRIVE, CHECK.
REQ-017 IDLE -> DRIVE at posedge when FIFO non-empty; the head is popped at that edge into register tgt_q.
REQ-018 Excitation from tracked state cur: tgt 1, cur 0 -> s=1,r=0; tgt 0, cur 1 -> s=0,r=1; tgt == cur -> s=0,r=0 (hold).
REQ-019 s and r are registered; they are non-zero only while state == DRIVE, for exactly one cycle per bit.
REQ-020 s and r shall never both be 1 in any cycle, including during and after reset.
REQ-021 DRIVE -> CHECK unconditionally after one cycle.
REQ-022 In CHECK, q_fb is compared with tgt_q at the closing posedge; on difference, mismatch = 1 for the next cycle and err_cnt increments.
REQ-023 err_cnt saturates at 2^ERR_W-1; it does not wrap.
REQ-024 At the CHECK closing edge, cur <= q_fb: resynchronise to the observed state, not the expected one.
REQ-025 CHECK -> DRIVE (popping the next head) if FIFO non-empty; otherwise CHECK -> IDLE.
REQ-026 Sustained throughput: 1 bit per 2 cycles.
REQ-027 Latency: bit pushed into an empty FIFO in IDLE at edge N gives s/r from edge N+1 and mismatch from edge N+3.
REQ-028 A push and a pop at the same edge are both honoured; occupancy is unchanged.

Reset
REQ-029 While reset = 0: state = IDLE, FIFO empty, tgt_ready = 0, s = r = 0, cur = 0, tgt_q = 0, mismatch = 0, err_cnt = 0, busy = 0.
REQ-030 Reset asserted mid-operation aborts immediately; queued bits are discarded and no pulse completes.
REQ-031 tgt_ready rises on the first posedge after reset deassertion.

Structure
REQ-032 Shared package sr_pkg holds the state enum (IDLE/DRIVE/CHECK) and the excitation encoding constants (HOLD, SET, RST).
REQ-033 The FIFO is a sub-module named sr_fifo, parameterised by DEPTH, with push/pop/full/empty/count ports.

Verification
REQ-034 Bench: sr_driver wired to the team's srff model (s, r, clk, reset, q -> q_fb), with reset active-low.
REQ-035 Push 1,0,0,1 after reset:
- s/r sequence is SET, RST, HOLD, SET.
- Final q_fb = 1.
- mismatch never pulses; err_cnt = 0.
REQ-036 Hold tgt_valid high with 6 bits while the FSM is stalled:
- tgt_ready drops after DEPTH=4 accepted.
- All 6 bits are eventually driven, in order.
REQ-037 Force q_fb = 0 while pushing target 1:
- mismatch pulses once at N+3; err_cnt = 1.
- The next target 1 produces SET again, since cur = 0.
REQ-038 ERR_W=2 with 5 forced mismatches: err_cnt reaches 3 and stays at 3.
REQ-039 Assert reset during DRIVE:
- s = r = 0 immediately; FIFO is empty.
- After release, a pushed 1 yields SET at N+1.
REQ-040 Random {valid, bit} for 200 cycles: s&r is never 1; q_fb always equals the last target with no mismatches.
